// File: rtl/score_display_pkg.sv
// Shared encodings for score_display: FSM states, 7-segment patterns (active-low, gfedcba)
// and the BCD-to-segment decoder.
package score_display_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_step.sv
// One double-dabble iteration on {bcd[11:0], bin[WIDTH-1:0]}: add 3 to every BCD nibble
// that is >= 5, then shift the whole vector left by one.
module bin2bcd_step #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH+11:0] din,
  output logic [WIDTH+11:0] dout
);

  logic [WIDTH+11:0] adj;

  always_comb begin
    adj = din;
    for (int d = 0; d < 3; d++) begin
      if (adj[WIDTH+4*d +: 4] >= 4'd5)
        adj[WIDTH+4*d +: 4] = adj[WIDTH+4*d +: 4] + 4'd3;
    end
    dout = {adj[WIDTH+10:0], 1'b0};
  end

endmodule

// File: rtl/score_display.sv
// Two-team score to six 7-segment digits via sequential double-dabble, started on change.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module score_display
  import score_display_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] home,
  input  logic [WIDTH-1:0] away,
  output logic [6:0]       hex5,
  output logic [6:0]       hex4,
  output logic [6:0]       hex3,
  output logic [6:0]       hex2,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0,
  output logic             busy,
  output logic             upd
);

  localparam int         BW   = WIDTH + 12;
  localparam logic [2:0] LAST = 3'(WIDTH - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [6:0] RST_LEAD_RAW = BLANK_EN ? SEG_BLANK : SEG_0;
  localparam logic [6:0] RST_LEAD     = (ACTIVE_LOW != 0) ? RST_LEAD_RAW : ~RST_LEAD_RAW;
  localparam logic [6:0] RST_UNIT     = (ACTIVE_LOW != 0) ? SEG_0 : ~SEG_0;

  function automatic logic [6:0] drive(input logic [6:0] seg);
    return (ACTIVE_LOW != 0) ? seg : ~seg;
  endfunction

  // zero_above: every more-significant digit is zero, so this one may be blanked
  function automatic logic [6:0] digit(input logic [3:0] d, input logic zero_above);
    return drive((BLANK_EN && zero_above && d == 4'd0) ? SEG_BLANK : seg_decode(d));
  endfunction

  logic [1:0]       state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] snap_h, snap_a;
  logic [BW-1:0]    sr_h, sr_a, nx_h, nx_a;

  bin2bcd_step #(.WIDTH(WIDTH)) u_step_h (.din(sr_h), .dout(nx_h));
  bin2bcd_step #(.WIDTH(WIDTH)) u_step_a (.din(sr_a), .dout(nx_a));

  logic [3:0] h_hun, h_ten, h_one, a_hun, a_ten, a_one;
  assign h_hun = sr_h[BW-1 -: 4];
  assign h_ten = sr_h[BW-5 -: 4];
  assign h_one = sr_h[BW-9 -: 4];
  assign a_hun = sr_a[BW-1 -: 4];
  assign a_ten = sr_a[BW-5 -: 4];
  assign a_one = sr_a[BW-9 -: 4];

  assign busy = (state == CONV) || (state == UPDATE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      snap_h <= '0;
      snap_a <= '0;
      sr_h   <= '0;
      sr_a   <= '0;
      upd    <= 1'b0;
      hex5   <= RST_LEAD;
      hex4   <= RST_LEAD;
      hex3   <= RST_UNIT;
      hex2   <= RST_LEAD;
      hex1   <= RST_LEAD;
      hex0   <= RST_UNIT;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if ({home, away} != {snap_h, snap_a}) begin
            snap_h <= home;
            snap_a <= away;
            sr_h   <= {{12{1'b0}}, home};
            sr_a   <= {{12{1'b0}}, away};
            cnt    <= 3'd0;
            state  <= CONV;
          end
        end
        CONV: begin
          sr_h <= nx_h;
          sr_a <= nx_a;
          cnt  <= cnt + 3'd1;
          if (cnt == LAST) state <= UPDATE;
        end
        UPDATE: begin
          hex5  <= digit(h_hun, 1'b1);
          hex4  <= digit(h_ten, h_hun == 4'd0);
          hex3  <= digit(h_one, 1'b0);
          hex2  <= digit(a_hun, 1'b1);
          hex1  <= digit(a_ten, a_hun == 4'd0);
          hex0  <= digit(a_one, 1'b0);
          upd   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: countdown-based reference model compared every cycle,
// plus literal segment/latency expectations for the directed scenarios.
module tb_score_display;

  localparam int ACTIVE_LOW = 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
  localparam logic [6:0] BLK   = 7'b1111111;
  localparam logic [6:0] LEAD0 = BLANK ? 7'b1111111 : 7'b1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] home = '0, away = '0;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic       busy, upd;

  int total = 0, bad = 0, upd_cnt = 0;

  score_display #(.WIDTH(7), .ACTIVE_LOW(ACTIVE_LOW)) dut (
    .clk(clk), .rst(rst), .home(home), .away(away),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .busy(busy), .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // pos: 0 units, 1 tens, 2 hundreds
  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int h, t, u, d;
    logic [6:0] p;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    d = (pos == 2) ? h : (pos == 1) ? t : u;
    if (BLANK && ((pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0))) p = BLK;
    else p = TBL[d];
    return (ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  // Model: a conversion is an 8-cycle busy window after the change is taken;
  // the display and the upd pulse land when the window closes.
  int         m_left, m_sh, m_sa;
  logic       m_upd;
  logic [6:0] m_hex [6];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_sh <= 0; m_sa <= 0; m_upd <= 1'b0;
      m_hex[5] <= LEAD0; m_hex[4] <= LEAD0; m_hex[3] <= TBL[0];
      m_hex[2] <= LEAD0; m_hex[1] <= LEAD0; m_hex[0] <= TBL[0];
    end else begin
      m_upd <= 1'b0;
      if (m_left == 0) begin
        if (int'(home) != m_sh || int'(away) != m_sa) begin
          m_sh <= int'(home); m_sa <= int'(away); m_left <= 8;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_upd <= 1'b1;
          m_hex[5] <= exp_seg(m_sh, 2); m_hex[4] <= exp_seg(m_sh, 1); m_hex[3] <= exp_seg(m_sh, 0);
          m_hex[2] <= exp_seg(m_sa, 2); m_hex[1] <= exp_seg(m_sa, 1); m_hex[0] <= exp_seg(m_sa, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {6'b0, busy}, {6'b0, m_left != 0});
    chk("upd",  {6'b0, upd},  {6'b0, m_upd});
    chk("hex5", hex5, m_hex[5]);
    chk("hex4", hex4, m_hex[4]);
    chk("hex3", hex3, m_hex[3]);
    chk("hex2", hex2, m_hex[2]);
    chk("hex1", hex1, m_hex[1]);
    chk("hex0", hex0, m_hex[0]);
    if (upd) upd_cnt++;
  end

  // Counts negedges until upd is seen; expired bound is a failure.
  task automatic wait_upd(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (upd) return;
    end
    total++; bad++;
    $display("FAIL wait_upd: no upd within 40 cycles at %0t", $time);
  endtask

  task automatic set_inputs(input int h, input int a);
    #1;
    home = 7'(h);
    away = 7'(a);
  endtask

  int n, u0;

  initial begin
    // 1: reset, scores zero, nothing converts
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_upd_count", 7'(upd_cnt), 7'd0);
    chk("rst_busy", {6'b0, busy}, 7'd0);
    chk("rst_hex3", hex3, 7'b1000000);
    chk("rst_hex0", hex0, 7'b1000000);
    chk("rst_hex5", hex5, LEAD0);

    // 2: home 0 -> 45, upd lands 9 edges after the change is set up
    u0 = upd_cnt;
    set_inputs(45, 0);
    wait_upd(n);
    chk("lat45", 7'(n), 7'd9);
    chk("h45_hex5", hex5, BLANK ? 7'b1111111 : 7'b1000000);
    chk("h45_hex4", hex4, 7'b0011001);
    chk("h45_hex3", hex3, 7'b0010010);
    repeat (10) @(negedge clk);
    chk("h45_one_upd", 7'(upd_cnt - u0), 7'd1);

    // 3: away 0 -> 127, home digits kept
    set_inputs(45, 127);
    wait_upd(n);
    chk("a127_hex2", hex2, 7'b1111001);
    chk("a127_hex1", hex1, 7'b0100100);
    chk("a127_hex0", hex0, 7'b1111000);
    chk("a127_hex3", hex3, 7'b0010010);
    repeat (3) @(negedge clk);

    // 4: 5 then 9 while busy: two clean updates
    u0 = upd_cnt;
    set_inputs(5, 127);
    repeat (3) @(negedge clk);
    set_inputs(9, 127);
    wait_upd(n);
    chk("mid_lat", 7'(n), 7'd6);
    chk("mid_hex3_5", hex3, 7'b0010010);
    wait_upd(n);
    chk("mid_lat2", 7'(n), 7'd9);
    chk("mid_hex3_9", hex3, 7'b0010000);
    repeat (10) @(negedge clk);
    chk("mid_two_upd", 7'(upd_cnt - u0), 7'd2);

    // 5: home+3 then reset mid-conversion, restart after release
    set_inputs(12, 127);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", {6'b0, busy}, 7'd0);
    chk("mrst_upd", {6'b0, upd}, 7'd0);
    chk("mrst_hex3", hex3, 7'b1000000);
    chk("mrst_hex4", hex4, LEAD0);
    chk("mrst_hex0", hex0, 7'b1000000);
    #1 rst = 1'b0;
    wait_upd(n);
    chk("rest_hex4", hex4, 7'b1111001);
    chk("rest_hex3", hex3, 7'b0100100);
    chk("rest_hex5", hex5, BLANK ? 7'b1111111 : 7'b1000000);

    // 6: home 7, leading digits depend on blanking
    set_inputs(7, 0);
    wait_upd(n);
    chk("h7_hex3", hex3, 7'b1111000);
    chk("h7_hex4", hex4, BLANK ? 7'b1111111 : 7'b1000000);
    chk("h7_hex5", hex5, BLANK ? 7'b1111111 : 7'b1000000);
    chk("h7_hex0", hex0, 7'b1000000);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
